// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring division, one quotient
// bit per cycle, with one-cycle fast paths for divide-by-zero and signed overflow.
module div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        flush_i,
   output logic        hold_o,
   output logic        ready_o,
   output logic [31:0] result_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_wen_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP,
      S_DONE
   } state_e;

   state_e      state_q;
   logic [4:0]  count_q;
   logic [1:0]  op_q;
   logic [4:0]  rd_addr_q;
   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic [31:0] dvsr_q;
   logic        qneg_q;
   logic        rneg_q;
   logic [31:0] result_q;
   logic        ready_q;

   logic        is_signed;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] rem_sh;
   logic [33:0] diff;
   logic [31:0] quot_d;
   logic [31:0] rem_d;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   // op_i[0] clear selects the signed variants (DIV, REM).
   assign is_signed = ~op_i[0];
   assign div_zero  = (divisor_i == 32'd0);
   assign div_ovf   = is_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
   assign abs_a     = (is_signed && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
   assign abs_b     = (is_signed && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rem_sh = {rem_q, quot_q[31]};
      diff   = {1'b0, rem_sh} - {2'b00, dvsr_q};
      quot_d = {quot_q[30:0], 1'b0};
      rem_d  = rem_sh[31:0];
      if (!diff[33]) begin
         quot_d[0] = 1'b1;
         rem_d     = diff[31:0];
      end
      q_fix = qneg_q ? (32'd0 - quot_q) : quot_q;
      r_fix = rneg_q ? (32'd0 - rem_q)  : rem_q;
   end

   assign hold_o    = ((state_q == S_IDLE) && start_i && !flush_i) ||
                      (state_q == S_CALC) || (state_q == S_FIXUP);
   assign ready_o   = ready_q;
   assign rd_wen_o  = ready_q;
   assign result_o  = result_q;
   assign rd_addr_o = rd_addr_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= 5'd0;
         op_q      <= 2'b00;
         rd_addr_q <= 5'd0;
         quot_q    <= 32'd0;
         rem_q     <= 32'd0;
         dvsr_q    <= 32'd0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         result_q  <= 32'd0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && !flush_i) begin
                  op_q      <= op_i;
                  rd_addr_q <= rd_addr_i;
                  count_q   <= 5'd0;
                  if (div_zero) begin
                     result_q <= op_i[1] ? dividend_i : 32'hFFFF_FFFF;
                     ready_q  <= 1'b1;
                     state_q  <= S_DONE;
                  end else if (div_ovf) begin
                     result_q <= op_i[1] ? 32'd0 : 32'h8000_0000;
                     ready_q  <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     quot_q  <= abs_a;
                     rem_q   <= 32'd0;
                     dvsr_q  <= abs_b;
                     qneg_q  <= is_signed && (dividend_i[31] ^ divisor_i[31]);
                     rneg_q  <= is_signed && dividend_i[31];
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (flush_i) begin
                  count_q <= 5'd0;
                  state_q <= S_IDLE;
               end else begin
                  quot_q  <= quot_d;
                  rem_q   <= rem_d;
                  count_q <= count_q + 5'd1;
                  if (count_q == 5'd31) state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               if (flush_i) begin
                  state_q <= S_IDLE;
               end else begin
                  result_q <= op_q[1] ? r_fix : q_fix;
                  ready_q  <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// fast paths, flush abort, mid-operation reset and ignored start requests.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        hold_o;
   logic        ready_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        rd_wen_o;

   int checks   = 0;
   int failures = 0;
   int lat;
   int hold_cnt;
   int ready_seen;
   logic hold_start;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   div_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_addr_i  (rd_addr_i),
      .flush_i    (flush_i),
      .hold_o     (hold_o),
      .ready_o    (ready_o),
      .result_o   (result_o),
      .rd_addr_o  (rd_addr_o),
      .rd_wen_o   (rd_wen_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a start request for one cycle at a falling edge; returns just after edge N.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      rd_addr_i  = rd;
      #1 hold_start = hold_o;
      @(negedge clk);
      start_i    = 1'b0;
      dividend_i = 32'hDEAD_BEEF;
      divisor_i  = 32'h0BAD_F00D;
   endtask

   // Counts edges since edge N (inclusive) until ready_o, and cycles with hold_o high.
   task automatic wait_ready(output int l, output int h);
      l = 1;
      h = hold_start ? 1 : 0;
      while (!ready_o && l < 100) begin
         if (hold_o) h++;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
      start_op(op, a, b, rd);
      wait_ready(lat, hold_cnt);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " result"}, result_o, exp_res);
      check({tag, " rd_addr"}, {27'd0, rd_addr_o}, {27'd0, rd});
      check({tag, " rd_wen"}, {31'd0, rd_wen_o}, 32'd1);
      check({tag, " hold in DONE"}, {31'd0, hold_o}, 32'd0);
      @(negedge clk);
      check({tag, " ready one-shot"}, {31'd0, ready_o}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      op_i       = 2'b00;
      dividend_i = 32'd0;
      divisor_i  = 32'd0;
      rd_addr_i  = 5'd0;
      hold_start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset hold", {31'd0, hold_o}, 32'd0);
      check("reset ready", {31'd0, ready_o}, 32'd0);
      check("reset rd_wen", {31'd0, rd_wen_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      check("reset rd_addr", {27'd0, rd_addr_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal path with latency and hold length.
      run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);
      check("divu hold cycles", hold_cnt, 34);
      run_op("div -20/3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd1, 32'hFFFF_FFFA, 34);
      run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34);
      run_op("remu ffffffff/16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd3, 32'd15, 34);
      run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 34);
      run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 34);
      run_op("divu 80000000/ffffffff", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 34);
      run_op("div 80000000/2", OP_DIV, 32'h8000_0000, 32'd2, 5'd7, 32'hC000_0000, 34);

      // Fast paths.
      run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
      check("fast hold cycles", hold_cnt, 1);
      run_op("rem 5/0", OP_REM, 32'd5, 32'd0, 5'd11, 32'd5, 1);
      run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
      run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

      // Flush at the 10th CALC cycle; result_o must keep the REM ovf value (0).
      start_op(OP_DIV, 32'd1000, 32'd10, 5'd14);
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      #1 check("flush hold before", {31'd0, hold_o}, 32'd1);
      @(negedge clk);
      flush_i = 1'b0;
      check("flush hold after", {31'd0, hold_o}, 32'd0);
      ready_seen = 0;
      repeat (40) begin
         if (ready_o) ready_seen++;
         @(negedge clk);
      end
      check("flush no ready", ready_seen, 0);
      check("flush result kept", result_o, 32'd0);
      run_op("divu 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 5'd15, 32'd3, 34);

      // Asynchronous reset at the 20th CALC cycle.
      start_op(OP_DIVU, 32'd77, 32'd7, 5'd16);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset hold", {31'd0, hold_o}, 32'd0);
      check("midreset ready", {31'd0, ready_o}, 32'd0);
      check("midreset rd_wen", {31'd0, rd_wen_o}, 32'd0);
      check("midreset result", result_o, 32'd0);
      check("midreset rd_addr", {27'd0, rd_addr_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post-reset idle hold", {31'd0, hold_o}, 32'd0);
      run_op("divu 50/5 after reset", OP_DIVU, 32'd50, 32'd5, 5'd17, 32'd10, 34);

      // start_i during CALC is ignored.
      start_op(OP_REMU, 32'd23, 32'd5, 5'd4);
      repeat (3) @(negedge clk);
      start_i    = 1'b1;
      op_i       = OP_DIVU;
      dividend_i = 32'd1;
      divisor_i  = 32'd1;
      rd_addr_i  = 5'd7;
      @(negedge clk);
      start_i = 1'b0;
      hold_start = 1'b1;
      wait_ready(lat, hold_cnt);
      check("ignore latency", lat + 4, 34);
      check("ignore result", result_o, 32'd3);
      check("ignore rd_addr", {27'd0, rd_addr_o}, 32'd4);
      @(negedge clk);
      ready_seen = 0;
      repeat (40) begin
         if (ready_o) ready_seen++;
         @(negedge clk);
      end
      check("ignore no second result", ready_seen, 0);

      // start_i with flush_i in IDLE is ignored.
      start_i    = 1'b1;
      flush_i    = 1'b1;
      op_i       = OP_DIVU;
      dividend_i = 32'd8;
      divisor_i  = 32'd0;
      rd_addr_i  = 5'd20;
      #1 check("start+flush hold", {31'd0, hold_o}, 32'd0);
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b0;
      ready_seen = 0;
      repeat (40) begin
         if (ready_o || hold_o) ready_seen++;
         @(negedge clk);
      end
      check("start+flush no activity", ready_seen, 0);
      check("start+flush result kept", result_o, 32'd3);
      check("start+flush rd kept", {27'd0, rd_addr_o}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider serving DIV, DIVU, REM and REMU for the execute stage. It sits beside the execute block. When that block decodes an R-type M-extension divide, it pulses a start request with both operands. The unit then holds the pipeline through its hold request for 34 cycles, and returns the quotient or remainder with its destination register for one cycle. Divide-by-zero and signed overflow finish in one cycle. A jump or flush from the control path aborts an operation in flight.

## Interface
- No parameters; data width is fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- op_i  in  2  func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  32  rs1 value.
- divisor_i  in  32  rs2 value.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  aborts any in-flight operation.
- hold_o  out  1  pipeline hold request to ctrl.
- ready_o  out  1  result valid for exactly one cycle.
- result_o  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- rd_addr_o  out  5  captured rd_addr_i.
- rd_wen_o  out  1  equals ready_o.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE + start_i + !flush_i: capture op, rd_addr and operands.
  - Signed ops: capture absolute values, and record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
  - Unsigned ops: no sign correction.
- Fast path, decided in IDLE from the raw operands; go to DONE with the result registered:
  - divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend_i.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Otherwise go to CALC with count = 0.
- CALC: restoring division, one bit per cycle.
  - Shift the 64-bit {rem, quot} left by 1.
  - Trial subtract: if rem[32:0] minus the 33-bit zero-extended divisor does not borrow, keep the difference and set quot[0] = 1.
  - count is 5 bits. After the iteration at count == 31, go to FIXUP.
- FIXUP: negate the quotient and/or remainder per the recorded signs, then select by op and register into result_o. Go to DONE.
- DONE: ready_o = rd_wen_o = 1. Go to IDLE the next edge regardless of start_i.
- hold_o is combinational: start_i in IDLE (unless flush_i), or state is CALC or FIXUP. It is 0 in DONE so the pipeline advances as the result writes back.
- flush_i in CALC or FIXUP: go to IDLE on the next edge, with no ready_o and result_o unchanged.
- flush_i in DONE: ignored; the result still issues.
- start_i outside IDLE: ignored.
- start_i together with flush_i in IDLE: ignored; hold_o = 0.
- Arithmetic widths:
  - All negation is 32-bit two's complement.
  - The absolute value of 0x80000000 is 0x80000000, treated as unsigned.
  - result_o holds its value between operations.

## Timing
- Reset: state = IDLE, count = 0, and hold_o, ready_o, rd_wen_o, result_o, rd_addr_o all 0. Reset mid-operation drops hold_o and ready_o immediately and asynchronously.
- Normal latency: start sampled at edge N. The 32 CALC iterations occur at edges N+1 to N+32, FIXUP at edge N+33, and ready_o is high from N+33 to N+34. hold_o is high from the start cycle through the FIXUP cycle.
- Fast-path latency: start sampled at edge N, ready_o high from N to N+1. hold_o is high only in the start cycle.
- Back-to-back: the earliest next start is the cycle after DONE, which is the first IDLE cycle.

## Test plan
- DIVU 100 / 7: ready_o exactly 34 edges after start, result_o = 14, rd_addr_o echoes 5'd9; hold_o high for 34 cycles then low in DONE.
- DIV −20 / 3 gives 0xFFFFFFFA (−6). REM −7 / 2 gives 0xFFFFFFFF (−1). REMU 0xFFFFFFFF / 16 gives 15.
- DIVU 5 / 0 gives 0xFFFFFFFF one edge after start. REM 5 / 0 gives 5. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 and REM gives 0; both fast path.
- Start DIV 1000 / 10, then assert flush_i at the 10th CALC cycle: no ready_o, hold_o drops the next cycle, result_o keeps its old value. A new DIVU 9 / 3 then returns 3.
- Assert rst_n low at the 20th CALC cycle: all outputs 0 immediately, state IDLE after release. A new start completes with the correct value.
- Drive start_i while CALC is active, and with flush_i high in IDLE: both are ignored, and only the first operation's result appears.
